arbitro_escrita_banco: RTL and testbench

- Write-port arbiter and sequencer for the 32x32 MIPS register file `banco_reg`.
- `banco_reg` has one write port (`sel`/`RegWrite`/`data`). This block shares it between two requesters: port 0 (ALU writeback) and port 1 (load writeback).
- Each requester gets a one-entry holding slot with valid/ready handshake. Arbitration is round-robin, with age priority on same-register conflicts.
- Outputs are registered and drive `banco_reg` directly. A busy vector is exported for hazard detection.

---
 rtl/banco_pkg.sv | 23 ++
 rtl/slot_escrita.sv | 57 +++++
 rtl/arbitro_escrita_banco.sv | 131 +++++++++++++
 tb/tb_arbitro_escrita_banco.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/banco_pkg.sv
// ----------------------------------------------------------------------------
// banco_pkg
// Shared constants and the holding-slot record used by the register-file
// write arbiter (arbitro_escrita_banco) and its slot sub-module.
// ----------------------------------------------------------------------------
package banco_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREG   = 1 << ADDR_W;

   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   // One buffered write. 'older' marks the slot that arrived first when both
   // slots hold writes; data keeps the [0:DATA_W-1] order of banco_reg.
   typedef struct packed {
      logic              valid;
      logic              older;
      logic [ADDR_W-1:0] addr;
      logic [0:DATA_W-1] data;
   } slot_t;

endpackage

// File: rtl/slot_escrita.sv
// ----------------------------------------------------------------------------
// slot_escrita
// One-entry holding slot for a register-file write requester.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_valid/i_addr/i_data   incoming write request
//   i_grant          this slot is granted the write port this cycle
//   i_other_accept   the sibling slot accepts a request this cycle
//   o_ready          slot can take a request this cycle
//   o_accept         request handshake completes at the next edge
//   o_slot           registered slot contents
// ----------------------------------------------------------------------------
module slot_escrita
   import banco_pkg::*;
#(
   parameter logic P_PORT0 = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [0:DATA_W-1] i_data,
   input  logic              i_grant,
   input  logic              i_other_accept,
   output logic              o_ready,
   output logic              o_accept,
   output slot_t             o_slot
);

   slot_t r_slot;

   // Ready depends only on registered state and the grant, which itself is
   // derived from registered state: no path from i_valid to o_ready.
   assign o_ready  = !r_slot.valid || i_grant;
   assign o_accept = i_valid && o_ready;
   assign o_slot   = r_slot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot <= '0;
      end else if (o_accept) begin
         r_slot.valid <= 1'b1;
         r_slot.addr  <= i_addr;
         r_slot.data  <= i_data;
         // A fresh entry is always the younger one, except when both ports
         // load together: then port 0 counts as older.
         r_slot.older <= P_PORT0 && i_other_accept;
      end else if (i_grant) begin
         r_slot.valid <= 1'b0;
         r_slot.older <= 1'b0;
      end else if (r_slot.valid && i_other_accept) begin
         // We stay buffered while the sibling takes a newer write.
         r_slot.older <= 1'b1;
      end
   end

endmodule

// File: rtl/arbitro_escrita_banco.sv
// ----------------------------------------------------------------------------
// arbitro_escrita_banco
// Shares the single write port of banco_reg between the ALU writeback
// (port 0) and the load writeback (port 1). Each port has a one-entry slot;
// arbitration is round-robin, with age order on same-register conflicts.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqK_valid/addr/data/ready    write request handshake, K = 0, 1
//   stall                         freeze arbitration while high
//   RegWrite, sel, data           registered write port to banco_reg
//   busy                          per-register pending-write vector
// ----------------------------------------------------------------------------
module arbitro_escrita_banco
   import banco_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [0:DATA_W-1] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [0:DATA_W-1] req1_data,
   output logic              req1_ready,
   input  logic              stall,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] sel,
   output logic [0:DATA_W-1] data,
   output logic [NREG-1:0]   busy
);

   slot_t             w_slot0, w_slot1, w_gnt_slot;
   logic              w_acc0, w_acc1;
   logic              w_grant0, w_grant1, w_rr_update;
   logic              r_last_grant;   // 1 = port 1 was granted last
   logic              r_regwrite;
   logic [ADDR_W-1:0] r_sel;
   logic [0:DATA_W-1] r_data;
   logic [NREG-1:0]   w_busy;

   slot_escrita #(.P_PORT0(1'b1)) u_slot0 (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_valid        (req0_valid),
      .i_addr         (req0_addr),
      .i_data         (req0_data),
      .i_grant        (w_grant0),
      .i_other_accept (w_acc1),
      .o_ready        (req0_ready),
      .o_accept       (w_acc0),
      .o_slot         (w_slot0)
   );

   slot_escrita #(.P_PORT0(1'b0)) u_slot1 (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_valid        (req1_valid),
      .i_addr         (req1_addr),
      .i_data         (req1_data),
      .i_grant        (w_grant1),
      .i_other_accept (w_acc0),
      .o_ready        (req1_ready),
      .o_accept       (w_acc1),
      .o_slot         (w_slot1)
   );

   always_comb begin
      w_grant0    = 1'b0;
      w_grant1    = 1'b0;
      w_rr_update = 1'b0;
      if (!stall) begin
         if (w_slot0.valid && w_slot1.valid) begin
            if (w_slot0.addr == w_slot1.addr) begin
               // Same destination: oldest first so the final value is right.
               if (w_slot0.older)      w_grant0 = 1'b1;
               else if (w_slot1.older) w_grant1 = 1'b1;
               else if (r_last_grant)  w_grant0 = 1'b1;
               else                    w_grant1 = 1'b1;
            end else begin
               w_rr_update = 1'b1;
               if (r_last_grant) w_grant0 = 1'b1;
               else              w_grant1 = 1'b1;
            end
         end else if (w_slot0.valid) begin
            w_grant0 = 1'b1;
         end else if (w_slot1.valid) begin
            w_grant1 = 1'b1;
         end
      end
   end

   assign w_gnt_slot = w_grant1 ? w_slot1 : w_slot0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
      end else if (w_rr_update) begin
         r_last_grant <= w_grant1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_regwrite <= 1'b0;
         r_sel      <= '0;
         r_data     <= '0;
      end else if (w_grant0 || w_grant1) begin
         // $zero writes still free the slot but never strobe RegWrite.
         r_regwrite <= (w_gnt_slot.addr != REG_ZERO);
         r_sel      <= w_gnt_slot.addr;
         r_data     <= w_gnt_slot.data;
      end else begin
         r_regwrite <= 1'b0;
      end
   end

   always_comb begin
      w_busy = '0;
      if (w_slot0.valid) w_busy[w_slot0.addr] = 1'b1;
      if (w_slot1.valid) w_busy[w_slot1.addr] = 1'b1;
      if (r_regwrite)    w_busy[r_sel]        = 1'b1;
      w_busy[0] = 1'b0;
   end

   assign busy     = w_busy;
   assign RegWrite = r_regwrite;
   assign sel      = r_sel;
   assign data     = r_data;

endmodule

// File: tb/tb_arbitro_escrita_banco.sv
module tb_arbitro_escrita_banco;

   logic        clk;
   logic        rst_n;
   logic        req0_valid;
   logic [4:0]  req0_addr;
   logic [0:31] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [4:0]  req1_addr;
   logic [0:31] req1_data;
   logic        req1_ready;
   logic        stall;
   logic        RegWrite;
   logic [4:0]  sel;
   logic [0:31] data;
   logic [31:0] busy;

   logic [0:31] rf [32];
   int n_cmp = 0;
   int n_err = 0;

   arbitro_escrita_banco dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .stall      (stall),
      .RegWrite   (RegWrite),
      .sel        (sel),
      .data       (data),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural banco_reg: written on the edge where RegWrite is high.
   always @(posedge clk) if (RegWrite) rf[sel] <= data;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      stall = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite got=%0b exp=0", RegWrite); end
      n_cmp++; if (sel !== 5'd0) begin n_err++; $display("FAIL reset_sel got=%0d exp=0", sel); end
      n_cmp++; if (data !== 32'd0) begin n_err++; $display("FAIL reset_data got=%0d exp=0", data); end
      n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL reset_busy got=%h exp=0", busy); end
      n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready0 got=%0b exp=1", req0_ready); end
      n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready1 got=%0b exp=1", req1_ready); end
      step();
      n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL idle_regwrite got=%0b exp=0", RegWrite); end
   endtask

   task automatic test_single_write();
      logic [31:0] exp_busy;
      exp_busy = 32'd1 << 18;
      do_reset();
      req0_valid = 1'b1; req0_addr = 5'd18; req0_data = 32'd70;
      step();                       // handshake edge
      req0_valid = 1'b0;
      n_cmp++; if (busy !== exp_busy) begin n_err++; $display("FAIL single_busy_buffered got=%h exp=%h", busy, exp_busy); end
      n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL single_early_regwrite got=%0b exp=0", RegWrite); end
      step();                       // second edge: write presented
      n_cmp++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL single_regwrite got=%0b exp=1", RegWrite); end
      n_cmp++; if (sel !== 5'd18) begin n_err++; $display("FAIL single_sel got=%0d exp=18", sel); end
      n_cmp++; if (data !== 32'd70) begin n_err++; $display("FAIL single_data got=%0d exp=70", data); end
      n_cmp++; if (busy !== exp_busy) begin n_err++; $display("FAIL single_busy_presented got=%h exp=%h", busy, exp_busy); end
      step();
      n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL single_regwrite_drop got=%0b exp=0", RegWrite); end
      n_cmp++; if (rf[18] !== 32'd70) begin n_err++; $display("FAIL single_rf18 got=%0d exp=70", rf[18]); end
      n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL single_busy_clear got=%h exp=0", busy); end
   endtask

   task automatic test_round_robin();
      logic [4:0]  exp_sel;
      logic [31:0] exp_data;
      logic        exp_r0, exp_r1;
      do_reset();
      req0_valid = 1'b1; req0_addr = 5'd15; req0_data = 32'd180;
      req1_valid = 1'b1; req1_addr = 5'd30; req1_data = 32'd360;
      step();                       // both slots load, port 0 older
      n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL rr_first_ready0 got=%0b exp=1", req0_ready); end
      n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL rr_first_ready1 got=%0b exp=0", req1_ready); end
      for (int k = 0; k < 6; k++) begin
         step();
         exp_sel  = (k % 2 == 0) ? 5'd15 : 5'd30;
         exp_data = (k % 2 == 0) ? 32'd180 : 32'd360;
         exp_r0   = (k % 2 != 0);
         exp_r1   = (k % 2 == 0);
         n_cmp++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL rr_regwrite k=%0d got=%0b exp=1", k, RegWrite); end
         n_cmp++; if (sel !== exp_sel) begin n_err++; $display("FAIL rr_sel k=%0d got=%0d exp=%0d", k, sel, exp_sel); end
         n_cmp++; if (data !== exp_data) begin n_err++; $display("FAIL rr_data k=%0d got=%0d exp=%0d", k, data, exp_data); end
         n_cmp++; if (req0_ready !== exp_r0) begin n_err++; $display("FAIL rr_ready0 k=%0d got=%0b exp=%0b", k, req0_ready, exp_r0); end
         n_cmp++; if (req1_ready !== exp_r1) begin n_err++; $display("FAIL rr_ready1 k=%0d got=%0b exp=%0b", k, req1_ready, exp_r1); end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_same_addr();
      logic [31:0] exp_busy;
      exp_busy = 32'd1 << 9;
      do_reset();
      // Hold arbitration so both writes to r9 coexist; round-robin alone
      // would pick port 0 first, age order must pick port 1.
      stall = 1'b1;
      req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'd5;
      step();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'd7;
      n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL same_ready0_empty got=%0b exp=1", req0_ready); end
      step();
      req0_valid = 1'b0;
      n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL same_ready0_stall got=%0b exp=0", req0_ready); end
      n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL same_ready1_stall got=%0b exp=0", req1_ready); end
      n_cmp++; if (busy !== exp_busy) begin n_err++; $display("FAIL same_busy got=%h exp=%h", busy, exp_busy); end
      stall = 1'b0;
      step();
      n_cmp++; if (RegWrite !== 1'b1 || sel !== 5'd9 || data !== 32'd5) begin n_err++; $display("FAIL same_first got=%0b/%0d/%0d exp=1/9/5", RegWrite, sel, data); end
      step();
      n_cmp++; if (RegWrite !== 1'b1 || sel !== 5'd9 || data !== 32'd7) begin n_err++; $display("FAIL same_second got=%0b/%0d/%0d exp=1/9/7", RegWrite, sel, data); end
      step();
      n_cmp++; if (rf[9] !== 32'd7) begin n_err++; $display("FAIL same_rf9 got=%0d exp=7", rf[9]); end
      n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL same_drop got=%0b exp=0", RegWrite); end
   endtask

   task automatic test_zero_write();
      do_reset();
      req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'd12;
      step();
      req0_valid = 1'b0;
      n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL zero_busy_buffered got=%h exp=0", busy); end
      step();
      n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL zero_regwrite got=%0b exp=0", RegWrite); end
      n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL zero_busy got=%h exp=0", busy); end
      n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready0 got=%0b exp=1", req0_ready); end
      step();
      n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL zero_regwrite_late got=%0b exp=0", RegWrite); end
   endtask

   task automatic test_stall_reset();
      logic [31:0] exp_busy;
      exp_busy = (32'd1 << 3) | (32'd1 << 4);
      do_reset();
      stall = 1'b1;
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'd33;
      req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'd44;
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL stall_regwrite k=%0d got=%0b exp=0", k, RegWrite); end
         n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready k=%0d got=%0b%0b exp=00", k, req0_ready, req1_ready); end
         n_cmp++; if (busy !== exp_busy) begin n_err++; $display("FAIL stall_busy k=%0d got=%h exp=%h", k, busy, exp_busy); end
      end
      #2 rst_n = 1'b0;              // asynchronous, between edges
      #1;
      n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL midreset_busy got=%h exp=0", busy); end
      n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin n_err++; $display("FAIL midreset_ready got=%0b%0b exp=11", req0_ready, req1_ready); end
      step();
      rst_n = 1'b1;
      stall = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL postreset_regwrite k=%0d got=%0b sel=%0d exp=0", k, RegWrite, sel); end
         n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL postreset_busy k=%0d got=%h exp=0", k, busy); end
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_round_robin();
      test_same_addr();
      test_zero_write();
      test_stall_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
